// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle engine.
//   level_cfg_t : per-level obstacle speed, spawn period and spawn row
//   LEVEL_CFG   : 20-entry level table, indexed by the decoded level number
//   state_t     : engine state (IDLE, RUN, DEAD)
//   lowest_set  : one-hot-ish level enable decode, lowest set bit wins
package obstacle_pkg;

  localparam int SCREEN_H = 480;
  localparam int N_LEVELS = 20;

  typedef struct packed {
    logic [3:0] speed;    // px moved left per frame
    logic [7:0] period;   // frames between spawns
    logic [9:0] spawn_y;  // row used when the LFSR is not built
  } level_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam level_cfg_t LEVEL_CFG [N_LEVELS] = '{
    '{4'd4,  8'd4,   10'd200},
    '{4'd6,  8'd200, 10'd300},
    '{4'd3,  8'd40,  10'd100},
    '{4'd4,  8'd32,  10'd150},
    '{4'd5,  8'd30,  10'd250},
    '{4'd5,  8'd24,  10'd350},
    '{4'd6,  8'd24,  10'd50},
    '{4'd6,  8'd20,  10'd400},
    '{4'd7,  8'd20,  10'd120},
    '{4'd7,  8'd18,  10'd220},
    '{4'd8,  8'd18,  10'd320},
    '{4'd8,  8'd16,  10'd420},
    '{4'd9,  8'd16,  10'd80},
    '{4'd9,  8'd14,  10'd180},
    '{4'd10, 8'd14,  10'd280},
    '{4'd10, 8'd12,  10'd380},
    '{4'd11, 8'd12,  10'd60},
    '{4'd12, 8'd10,  10'd160},
    '{4'd13, 8'd10,  10'd260},
    '{4'd15, 8'd8,   10'd360}
  };

  // Index of the lowest set bit; 0 when no bit is set (caller treats that as IDLE).
  function automatic logic [4:0] lowest_set(input logic [19:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 19; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
// Only built when OBSTACLE_LFSR_EN is defined.
//   clk, reset : clock, asynchronous active-high reset (reseeds)
//   en         : advance one step this cycle
//   value      : current LFSR state
module obstacle_lfsr (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] value
);

  // LFSR state: right-shifting Galois form, taps 0xB400.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 16'hACE1;
    end else if (en) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/obstacle_engine.sv
// Obstacle engine: runs a fixed pool of obstacle slots once per frame_tick
// (spawn at the right edge, move left, retire off the left edge), counts
// frames and dodged obstacles, and flags player/obstacle overlap.
// Optional feature: define OBSTACLE_LFSR_EN to draw spawn rows from a
// 16-bit LFSR instead of the per-level table value.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   frame_tick        1-cycle pulse per video frame
//   level_sel[19:0]   level enables, lowest set bit selects the level
//   menu_screen       sequencer in menu (forces IDLE)
//   win_screen        sequencer in win screen (forces IDLE)
//   player_x/y[9:0]   player top-left corner
//   game_time[10:0]   frames since run start, saturating
//   obj_count[10:0]   obstacles retired, saturating
//   player_died       1-cycle pulse, two cycles after the colliding tick
//   obj_valid/obj_x/obj_y  slot table for the renderer, slot i at [10i+:10]
module obstacle_engine
  import obstacle_pkg::*;
#(
  parameter int N_OBJ    = 8,
  parameter int SCREEN_W = 640,
  parameter int OBJ_W    = 16,
  parameter int PLAYER_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [19:0]          level_sel,
  input  logic                 menu_screen,
  input  logic                 win_screen,
  input  logic [9:0]           player_x,
  input  logic [9:0]           player_y,
  output logic [10:0]          game_time,
  output logic [10:0]          obj_count,
  output logic                 player_died,
  output logic [N_OBJ-1:0]     obj_valid,
  output logic [10*N_OBJ-1:0]  obj_x,
  output logic [10*N_OBJ-1:0]  obj_y
);

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  state_t            state_r, state_nxt;
  logic              idle_cond;
  logic              clear;
  logic              run_tick;
  level_cfg_t        cfg;
  logic [9:0]        spawn_y;

  logic [N_OBJ-1:0]  valid_r, valid_nxt;
  logic [9:0]        x_r [N_OBJ];
  logic [9:0]        y_r [N_OBJ];
  logic [9:0]        x_nxt [N_OBJ];
  logic [9:0]        y_nxt [N_OBJ];
  logic [7:0]        spawn_cnt_r, spawn_cnt_nxt;
  logic              spawn_due;
  logic [IW-1:0]     spawn_slot;
  logic              free_found;
  logic [4:0]        retire_cnt;
  logic [11:0]       count_sum;
  logic              moved_r;
  logic              hit;
  logic              died_nxt;

  // Half of the 11-bit box test: object span [o, o+OBJ_W) vs player span [p, p+PLAYER_W).
  function automatic logic spans_overlap(input logic [9:0] o, input logic [9:0] p);
    logic [10:0] o_w, p_w;
    o_w = {1'b0, o};
    p_w = {1'b0, p};
    return (o_w < p_w + 11'(PLAYER_W)) && (p_w < o_w + 11'(OBJ_W));
  endfunction

  assign idle_cond = menu_screen | win_screen | (level_sel == 20'd0);
  assign cfg       = LEVEL_CFG[lowest_set(level_sel)];
  // Ticks only count in RUN; a flag raised in the same cycle wins and clears.
  assign run_tick  = (state_r == RUN) && !idle_cond && frame_tick;
  assign clear     = (state_r != RUN) || idle_cond;

`ifdef OBSTACLE_LFSR_EN
  logic [15:0] lfsr_value;
  logic [9:0]  lfsr_low;

  obstacle_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (run_tick),
    .value (lfsr_value)
  );

  // lfsr_low < 2*(SCREEN_H-OBJ_W), so one conditional subtract is the modulo.
  assign lfsr_low = {1'b0, lfsr_value[8:0]};
  assign spawn_y  = (lfsr_low >= 10'(SCREEN_H - OBJ_W)) ? (lfsr_low - 10'(SCREEN_H - OBJ_W))
                                                        : lfsr_low;
`else
  assign spawn_y = cfg.spawn_y;
`endif

  // Spawn timing: counter reloads on every due tick, even if the spawn is dropped.
  always_comb begin
    spawn_due     = ({1'b0, spawn_cnt_r} + 9'd1) >= {1'b0, cfg.period};
    spawn_cnt_nxt = spawn_due ? 8'd0 : (spawn_cnt_r + 8'd1);
  end

  // Per-tick slot update: move/retire every valid slot, then spawn into the
  // lowest slot that was already free before this tick.
  always_comb begin
    valid_nxt  = valid_r;
    x_nxt      = x_r;
    y_nxt      = y_r;
    retire_cnt = 5'd0;
    spawn_slot = '0;
    free_found = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!valid_r[i] && !free_found) begin
        spawn_slot = IW'(i);
        free_found = 1'b1;
      end else begin
        free_found = free_found;
      end
    end
    for (int i = 0; i < N_OBJ; i++) begin
      if (valid_r[i]) begin
        if (x_r[i] < {6'd0, cfg.speed}) begin
          valid_nxt[i] = 1'b0;
          retire_cnt   = retire_cnt + 5'd1;
        end else begin
          x_nxt[i] = x_r[i] - {6'd0, cfg.speed};
        end
      end else begin
        valid_nxt[i] = 1'b0;
      end
    end
    if (spawn_due && free_found) begin
      valid_nxt[spawn_slot] = 1'b1;
      x_nxt[spawn_slot]     = 10'(SCREEN_W);
      y_nxt[spawn_slot]     = spawn_y;
    end else begin
      valid_nxt = valid_nxt;
    end
    count_sum = {1'b0, obj_count} + {7'd0, retire_cnt};
  end

  // Overlap test against the current (already moved) slot positions.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (valid_r[i] && spans_overlap(x_r[i], player_x) && spans_overlap(y_r[i], player_y)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    // Only the cycle right after a move is checked, giving tick + 2 for the pulse.
    died_nxt = moved_r && hit;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (idle_cond) state_nxt = IDLE;
        else           state_nxt = RUN;
      end
      RUN: begin
        if (idle_cond)     state_nxt = IDLE;
        else if (died_nxt) state_nxt = DEAD;
        else               state_nxt = RUN;
      end
      DEAD: begin
        if (idle_cond) state_nxt = IDLE;
        else           state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt;
  end

  // Slot table, counters and collision pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r     <= '0;
      spawn_cnt_r <= 8'd0;
      game_time   <= 11'd0;
      obj_count   <= 11'd0;
      player_died <= 1'b0;
      moved_r     <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_r[i] <= 10'd0;
        y_r[i] <= 10'd0;
      end
    end else if (clear) begin
      valid_r     <= '0;
      spawn_cnt_r <= 8'd0;
      game_time   <= 11'd0;
      obj_count   <= 11'd0;
      player_died <= 1'b0;
      moved_r     <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_r[i] <= 10'd0;
        y_r[i] <= 10'd0;
      end
    end else begin
      player_died <= died_nxt;
      moved_r     <= run_tick;
      if (run_tick) begin
        valid_r     <= valid_nxt;
        spawn_cnt_r <= spawn_cnt_nxt;
        game_time   <= (game_time == 11'd2047) ? game_time : (game_time + 11'd1);
        obj_count   <= (count_sum > 12'd2047) ? 11'd2047 : count_sum[10:0];
        for (int i = 0; i < N_OBJ; i++) begin
          x_r[i] <= x_nxt[i];
          y_r[i] <= y_nxt[i];
        end
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign obj_valid = valid_r;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
    assign obj_x[10*g +: 10] = x_r[g];
    assign obj_y[10*g +: 10] = y_r[g];
  end

endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench for obstacle_engine (default 8 slots, level table from
// obstacle_pkg). Expected values are worked out by hand from the level
// parameters: level 0 = speed 4 / period 4 / y 200, level 1 = speed 6 /
// period 200 / y 300.
module tb_obstacle_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_tick;
  logic [19:0]  level_sel;
  logic         menu_screen;
  logic         win_screen;
  logic [9:0]   player_x;
  logic [9:0]   player_y;
  logic [10:0]  game_time;
  logic [10:0]  obj_count;
  logic         player_died;
  logic [7:0]   obj_valid;
  logic [79:0]  obj_x;
  logic [79:0]  obj_y;

  int n_vec  = 0;
  int n_miss = 0;

  obstacle_engine dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .level_sel   (level_sel),
    .menu_screen (menu_screen),
    .win_screen  (win_screen),
    .player_x    (player_x),
    .player_y    (player_y),
    .game_time   (game_time),
    .obj_count   (obj_count),
    .player_died (player_died),
    .obj_valid   (obj_valid),
    .obj_x       (obj_x),
    .obj_y       (obj_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] sx(input int i);
    return obj_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return obj_y[10*i +: 10];
  endfunction

  // Spawn row check; with the LFSR built only the legal range is known here.
  task automatic check_y(input string tag, input int slot, input logic [9:0] exp);
`ifdef OBSTACLE_LFSR_EN
    check(tag, 32'(sy(slot) < 10'd464), 32'd1);
`else
    check(tag, 32'(sy(slot)), 32'(exp));
`endif
  endtask

  // One frame_tick; returns at the negedge after the collision register has updated.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(obj_valid), 32'd0);
    check({tag, "_time"},  32'(game_time), 32'd0);
    check({tag, "_count"}, 32'(obj_count), 32'd0);
    check({tag, "_xzero"}, 32'(obj_x == 80'd0), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    frame_tick  = 1'b0;
    menu_screen = 1'b0;
    win_screen  = 1'b0;
    level_sel   = 20'd0;
    player_x    = 10'd0;
    player_y    = 10'd600;
    repeat (3) @(negedge clk);
    check_cleared("rst");
    check("rst_died", 32'(player_died), 32'd0);

    // Level 0 run: spawns every 4th tick at x=640, moves 4 px per tick.
    @(negedge clk) reset = 1'b0;
    level_sel = 20'h00001;
    repeat (2) @(negedge clk);
    ticks(3);
    check("t3_valid", 32'(obj_valid), 32'd0);
    check("t3_time",  32'(game_time), 32'd3);
    tick();
    check("t4_valid", 32'(obj_valid), 32'h01);
    check("t4_x0",    32'(sx(0)), 32'd640);
    check_y("t4_y0", 0, 10'd200);
    tick();
    check("t5_x0",    32'(sx(0)), 32'd636);
    check("t5_time",  32'(game_time), 32'd5);

    // Pool fills at tick 32; the tick-36 spawn is dropped without overwriting.
    ticks(27);
    check("t32_valid", 32'(obj_valid), 32'hFF);
    check("t32_x0",    32'(sx(0)), 32'd528);
    check("t32_x7",    32'(sx(7)), 32'd640);
    ticks(4);
    check("t36_valid", 32'(obj_valid), 32'hFF);
    check("t36_x0",    32'(sx(0)), 32'd512);
    check("t36_x7",    32'(sx(7)), 32'd624);

    // Slot 0 reaches x=0 at tick 164, retires at 165, respawns at 168.
    ticks(128);
    check("t164_x0",    32'(sx(0)), 32'd0);
    check("t164_count", 32'(obj_count), 32'd0);
    tick();
    check("t165_valid", 32'(obj_valid), 32'hFE);
    check("t165_count", 32'(obj_count), 32'd1);
    check("t165_x1",    32'(sx(1)), 32'd12);
    ticks(3);
    check("t168_valid", 32'(obj_valid), 32'hFF);
    check("t168_x0",    32'(sx(0)), 32'd640);
    tick();
    check("t169_valid", 32'(obj_valid), 32'hFD);
    check("t169_count", 32'(obj_count), 32'd2);
    check("t169_x0",    32'(sx(0)), 32'd636);
    check("t169_time",  32'(game_time), 32'd169);

    // Menu during RUN clears everything and ticks are ignored.
    @(negedge clk) menu_screen = 1'b1;
    @(negedge clk);
    check_cleared("menu");
    tick();
    check("menu_tick_time", 32'(game_time), 32'd0);

    // Win screen also holds IDLE.
    menu_screen = 1'b0;
    win_screen  = 1'b1;
    tick();
    check("win_tick_time", 32'(game_time), 32'd0);

    // Level 1: a single obstacle travels to x=4 (< speed 6) and retires.
    @(negedge clk) win_screen = 1'b0;
    level_sel = 20'h00002;
    @(negedge clk);
    ticks(199);
    check("l1_t199_valid", 32'(obj_valid), 32'd0);
    check("l1_t199_time",  32'(game_time), 32'd199);
    tick();
    check("l1_t200_valid", 32'(obj_valid), 32'h01);
    check("l1_t200_x0",    32'(sx(0)), 32'd640);
    check_y("l1_t200_y0", 0, 10'd300);
    ticks(106);
    check("l1_t306_x0",    32'(sx(0)), 32'd4);
    tick();
    check("l1_t307_valid", 32'(obj_valid), 32'd0);
    check("l1_t307_count", 32'(obj_count), 32'd1);

    // Collision: levels 0 and 1 enabled, level 0 wins. Player at (320,200).
    @(negedge clk) menu_screen = 1'b1;
    level_sel = 20'h00003;
    player_x  = 10'd320;
    player_y  = 10'd200;
    @(negedge clk) menu_screen = 1'b0;
    @(negedge clk);
    ticks(80);
    check("c80_x0",   32'(sx(0)), 32'd336);
    check("c80_died", 32'(player_died), 32'd0);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("c81_x0",        32'(sx(0)), 32'd332);
    check("c81_died_early", 32'(player_died), 32'd0);
    @(negedge clk);
    check("c81_died",  32'(player_died), 32'd1);
    check("c81_time",  32'(game_time), 32'd81);
    check("c81_valid", 32'(obj_valid), 32'hFF);
    @(negedge clk);
    check("dead_died", 32'(player_died), 32'd0);
    check_cleared("dead");
    @(negedge clk);
    tick();
    check("rerun_time", 32'(game_time), 32'd1);
    check("rerun_died", 32'(player_died), 32'd0);

    // Asynchronous reset mid-run clears outputs before the next clock edge.
    ticks(3);
    check("pre_rst_valid", 32'(obj_valid), 32'h01);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_cleared("async_rst");
    check("async_rst_died", 32'(player_died), 32'd0);
    @(negedge clk) reset = 1'b0;
    level_sel = 20'd0;
    @(negedge clk);
    tick();
    check("nolevel_time", 32'(game_time), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
